// File: rtl/debug_uart_tx_pkg.sv
// Shared types and constants for the debug UART transmitter.
// Frame layout: SYNC, seven captured debug bytes, XOR checksum.
package debug_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int FRAME_BYTES   = 9;
  localparam int BITS_PER_BYTE = 10;
  localparam int PORT_BYTES    = 7;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] xor_bytes(
    input logic [7:0] b [PORT_BYTES]
  );
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < PORT_BYTES; i++) begin
      acc = acc ^ b[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/debug_uart_tx_if.sv
// Bundle between the cpu debug ports / host link and the transmitter.
// The master drives trigger and ports; the slave drives the serial side.
interface debug_uart_tx_if;

  logic       trigger;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_count;

  modport master (
    output trigger,
    output debug_port1,
    output debug_port2,
    output debug_port3,
    output debug_port4,
    output debug_port5,
    output debug_port6,
    output debug_port7,
    input  tx,
    input  busy,
    input  frame_done,
    input  drop_count
  );

  modport slave (
    input  trigger,
    input  debug_port1,
    input  debug_port2,
    input  debug_port3,
    input  debug_port4,
    input  debug_port5,
    input  debug_port6,
    input  debug_port7,
    output tx,
    output busy,
    output frame_done,
    output drop_count
  );

endinterface

// File: rtl/debug_uart_tx_byte.sv
// 8N1 byte serializer, LSB first, with a load/ready handshake.
// Ready rises in the last stop-bit cycle so bytes can be chained gaplessly.
module uart_tx_byte
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_last,
  output logic       o_tx
);

  localparam logic [15:0] BAUD_LAST =
    16'(CLKS_PER_BIT - 1);

  uart_state_e r_state;
  uart_state_e w_state_n;
  logic [15:0] r_baud;
  logic [15:0] w_baud_n;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_n;
  logic        r_tx;
  logic        w_tx_n;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    unique case (r_state)
      ST_IDLE: begin
        w_tx_n   = 1'b1;
        w_baud_n = '0;
        if (i_load) begin
          w_state_n = ST_START;
          w_shift_n = i_data;
          w_tx_n    = 1'b0;
        end
      end
      ST_START: begin
        w_baud_n = r_baud + 16'd1;
        if (w_bit_end) begin
          w_state_n = ST_DATA;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end
      end
      ST_DATA: begin
        w_baud_n = r_baud + 16'd1;
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_state_n = ST_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = r_shift >> 1;
            w_tx_n    = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        w_baud_n = r_baud + 16'd1;
        if (w_bit_end) begin
          w_baud_n = '0;
          // chaining straight into the next start bit
          if (i_load) begin
            w_state_n = ST_START;
            w_shift_n = i_data;
            w_tx_n    = 1'b0;
          end else begin
            w_state_n = ST_IDLE;
            w_tx_n    = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  assign o_last  = (r_state == ST_STOP) && w_bit_end;
  assign o_ready = (r_state == ST_IDLE) || o_last;
  assign o_tx    = r_tx;

endmodule

// File: rtl/debug_uart_tx.sv
// Captures the seven cpu debug bytes on trigger and ships them as
// one SYNC + data + XOR-checksum frame over an 8N1 UART line.
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  debug_uart_tx_if.slave  bus
);

  localparam logic [3:0] LAST_IDX =
    4'(FRAME_BYTES - 1);

  logic [7:0] r_cap [8];
  logic [3:0] r_idx;
  logic       r_busy;
  logic [7:0] r_drop;

  logic [7:0] w_ports [PORT_BYTES];
  logic [7:0] w_csum;
  logic       w_ready;
  logic       w_last;
  logic       w_tx;
  logic       w_frame_done;
  logic       w_accept;
  logic       w_drop;
  logic       w_next;
  logic       w_load;
  logic [7:0] w_data;

  assign w_ports[0] = bus.debug_port1;
  assign w_ports[1] = bus.debug_port2;
  assign w_ports[2] = bus.debug_port3;
  assign w_ports[3] = bus.debug_port4;
  assign w_ports[4] = bus.debug_port5;
  assign w_ports[5] = bus.debug_port6;
  assign w_ports[6] = bus.debug_port7;
  assign w_csum     = xor_bytes(w_ports);

  assign w_frame_done = r_busy && w_last &&
                        (r_idx == LAST_IDX);
  assign w_accept = bus.trigger && w_ready &&
                    (!r_busy || w_frame_done);
  assign w_drop   = bus.trigger && r_busy &&
                    !w_frame_done;
  assign w_next   = r_busy && w_last &&
                    !w_frame_done;

  // slot 7 of the shadow holds the checksum
  always_comb begin
    w_load = w_accept || w_next;
    w_data = SYNC_BYTE;
    if (w_next) begin
      w_data = r_cap[r_idx[2:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_cap[i] <= '0;
      end
      r_idx  <= '0;
      r_busy <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < PORT_BYTES; i++) begin
        r_cap[i] <= w_ports[i];
      end
      r_cap[7] <= w_csum;
      r_idx    <= '0;
      r_busy   <= 1'b1;
    end else if (w_next) begin
      r_idx <= r_idx + 4'd1;
    end else if (w_frame_done) begin
      r_idx  <= '0;
      r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_data),
    .o_ready (w_ready),
    .o_last  (w_last),
    .o_tx    (w_tx)
  );

  assign bus.tx         = w_tx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = w_frame_done;
  assign bus.drop_count = r_drop;

endmodule
